// File: rtl/branch_rs_if.sv
// Bundles the dispatch, CDB, comparator and result signals of the branch reservation station.
// The master side is the environment (dispatch/CDB/comparator); the slave side is the RS itself.
interface branch_rs_if #(
  parameter int TAG_W = 3,
  parameter int WIDTH = 32
);
  logic             alloc_valid;
  logic             alloc_ready;
  logic [2:0]       alloc_cmpop;
  logic [WIDTH-1:0] alloc_src1_val;
  logic [WIDTH-1:0] alloc_src2_val;
  logic             alloc_src1_rdy;
  logic             alloc_src2_rdy;
  logic [TAG_W-1:0] alloc_src1_tag;
  logic [TAG_W-1:0] alloc_src2_tag;
  logic [TAG_W-1:0] alloc_rob_tag;

  logic             cdb_valid;
  logic [TAG_W-1:0] cdb_tag;
  logic [WIDTH-1:0] cdb_value;

  logic             flush;

  logic             cmp_load;
  logic [2:0]       cmp_op;
  logic [WIDTH-1:0] cmp_a;
  logic [WIDTH-1:0] cmp_b;
  logic             cmp_ready;
  logic             cmp_f;

  logic             res_valid;
  logic [TAG_W-1:0] res_rob_tag;
  logic             res_taken;

  modport master (
    output alloc_valid, alloc_cmpop, alloc_src1_val, alloc_src2_val,
           alloc_src1_rdy, alloc_src2_rdy, alloc_src1_tag, alloc_src2_tag, alloc_rob_tag,
           cdb_valid, cdb_tag, cdb_value, flush, cmp_ready, cmp_f,
    input  alloc_ready, cmp_load, cmp_op, cmp_a, cmp_b, res_valid, res_rob_tag, res_taken
  );

  modport slave (
    input  alloc_valid, alloc_cmpop, alloc_src1_val, alloc_src2_val,
           alloc_src1_rdy, alloc_src2_rdy, alloc_src1_tag, alloc_src2_tag, alloc_rob_tag,
           cdb_valid, cdb_tag, cdb_value, flush, cmp_ready, cmp_f,
    output alloc_ready, cmp_load, cmp_op, cmp_a, cmp_b, res_valid, res_rob_tag, res_taken
  );
endinterface

// File: rtl/branch_rs.sv
// Branch reservation station: collapsing queue, oldest-ready issue; ready op -> cmp_load +1, result +3 cycles.
// Backpressure: alloc_ready drops while all DEPTH entries are held; only one op may be outstanding at the comparator.
module branch_rs #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 3,
  parameter int WIDTH = 32
) (
  input logic        clk,
  input logic        rst,
  branch_rs_if.slave bus
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = $clog2(DEPTH);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;

  typedef struct packed {
    logic             vld;
    logic [2:0]       op;
    logic             s1_rdy;
    logic [TAG_W-1:0] s1_tag;
    logic [WIDTH-1:0] s1_val;
    logic             s2_rdy;
    logic [TAG_W-1:0] s2_tag;
    logic [WIDTH-1:0] s2_val;
    logic [TAG_W-1:0] rob_tag;
  } ent_t;

  ent_t             ent_q [DEPTH];
  ent_t             ent_d [DEPTH];
  ent_t             woke  [DEPTH+1];
  ent_t             new_ent;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic [CNT_W-1:0] count_base;
  logic [0:0]       state_q;
  logic [IDX_W-1:0] sel;
  logic             sel_found;
  logic             do_issue;
  logic             alloc_fire;

  logic             cmp_load_q;
  logic [2:0]       cmp_op_q;
  logic [WIDTH-1:0] cmp_a_q;
  logic [WIDTH-1:0] cmp_b_q;
  logic [TAG_W-1:0] issue_tag_q;
  logic             res_valid_q;
  logic [TAG_W-1:0] res_rob_tag_q;
  logic             res_taken_q;

  function automatic ent_t snoop(input ent_t e, input logic cv,
                                 input logic [TAG_W-1:0] ct, input logic [WIDTH-1:0] cval);
    ent_t r;
    r = e;
    if (cv && r.vld) begin
      if (!r.s1_rdy && r.s1_tag == ct) begin
        r.s1_rdy = 1'b1;
        r.s1_val = cval;
      end
      if (!r.s2_rdy && r.s2_tag == ct) begin
        r.s2_rdy = 1'b1;
        r.s2_val = cval;
      end
    end
    return r;
  endfunction

  assign bus.alloc_ready = (count_q < CNT_W'(DEPTH));
  assign alloc_fire      = bus.alloc_valid && bus.alloc_ready;
  assign do_issue        = (state_q == S_IDLE) && sel_found;

  // Readiness is judged on registered state: a CDB hit this cycle makes an entry issuable next cycle.
  always_comb begin
    sel       = '0;
    sel_found = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (ent_q[i].vld && ent_q[i].s1_rdy && ent_q[i].s2_rdy) begin
        sel       = IDX_W'(i);
        sel_found = 1'b1;
      end
    end
  end

  always_comb begin
    new_ent         = '0;
    new_ent.vld     = 1'b1;
    new_ent.op      = bus.alloc_cmpop;
    new_ent.s1_rdy  = bus.alloc_src1_rdy;
    new_ent.s1_tag  = bus.alloc_src1_tag;
    new_ent.s1_val  = bus.alloc_src1_val;
    new_ent.s2_rdy  = bus.alloc_src2_rdy;
    new_ent.s2_tag  = bus.alloc_src2_tag;
    new_ent.s2_val  = bus.alloc_src2_val;
    new_ent.rob_tag = bus.alloc_rob_tag;
    new_ent         = snoop(new_ent, bus.cdb_valid, bus.cdb_tag, bus.cdb_value);
  end

  // Wakeup, collapse past the issued slot, then append the new op behind the survivors.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      woke[i] = snoop(ent_q[i], bus.cdb_valid, bus.cdb_tag, bus.cdb_value);
    end
    woke[DEPTH] = '0;
    count_base  = count_q - CNT_W'(do_issue);
    count_d     = count_base + CNT_W'(alloc_fire);
    for (int i = 0; i < DEPTH; i++) begin
      ent_d[i] = (do_issue && IDX_W'(i) >= sel) ? woke[i+1] : woke[i];
      if (alloc_fire && CNT_W'(i) == count_base) begin
        ent_d[i] = new_ent;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '0;
      end
      count_q       <= '0;
      state_q       <= S_IDLE;
      cmp_load_q    <= 1'b0;
      cmp_op_q      <= '0;
      cmp_a_q       <= '0;
      cmp_b_q       <= '0;
      issue_tag_q   <= '0;
      res_valid_q   <= 1'b0;
      res_rob_tag_q <= '0;
      res_taken_q   <= 1'b0;
    end else if (bus.flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '0;
      end
      count_q     <= '0;
      state_q     <= S_IDLE;
      cmp_load_q  <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= ent_d[i];
      end
      count_q     <= count_d;
      cmp_load_q  <= 1'b0;
      res_valid_q <= 1'b0;
      if (do_issue) begin
        state_q     <= S_WAIT;
        cmp_load_q  <= 1'b1;
        cmp_op_q    <= ent_q[sel].op;
        cmp_a_q     <= ent_q[sel].s1_val;
        cmp_b_q     <= ent_q[sel].s2_val;
        issue_tag_q <= ent_q[sel].rob_tag;
      end else if (state_q == S_WAIT && bus.cmp_ready) begin
        state_q       <= S_IDLE;
        res_valid_q   <= 1'b1;
        res_rob_tag_q <= issue_tag_q;
        res_taken_q   <= bus.cmp_f;
      end
    end
  end

  assign bus.cmp_load    = cmp_load_q;
  assign bus.cmp_op      = cmp_op_q;
  assign bus.cmp_a       = cmp_a_q;
  assign bus.cmp_b       = cmp_b_q;
  assign bus.res_valid   = res_valid_q;
  assign bus.res_rob_tag = res_rob_tag_q;
  assign bus.res_taken   = res_taken_q;

endmodule

// File: tb/tb_branch_rs.sv
// Bench for branch_rs: directed vector table and corner sequences, then random traffic
// checked every cycle against a queue-based reference model of the reservation station.
module tb_branch_rs;
  localparam int DEPTH = 4;
  localparam int TAG_W = 3;
  localparam int WIDTH = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  branch_rs_if #(.TAG_W(TAG_W), .WIDTH(WIDTH)) bus ();

  branch_rs #(.DEPTH(DEPTH), .TAG_W(TAG_W), .WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] v1;
    logic [31:0] v2;
    bit          r1;
    bit          r2;
    logic [2:0]  t1;
    logic [2:0]  t2;
    logic [2:0]  rob;
  } op_t;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  rob;
    logic        taken;
  } vec_t;

  // Reference model state: pending ops oldest-first, plus the op held by the comparator.
  op_t        q[$];
  op_t        iss;
  bit         busy;
  logic       exp_load;
  logic       exp_res_v;
  logic       exp_taken;
  logic [2:0] exp_tag;

  int n_checks;
  int n_errors;
  bit auto_cmp;
  bit pend;
  int wait_cnt;
  int cmp_delay_max;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic ref_cmp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'b000:  return a == b;
      3'b001:  return a != b;
      3'b100:  return $signed(a) <  $signed(b);
      3'b101:  return $signed(a) >= $signed(b);
      3'b110:  return a <  b;
      3'b111:  return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic op_t mk(input logic [2:0] op, input logic [31:0] v1, input bit r1, input logic [2:0] t1,
                             input logic [31:0] v2, input bit r2, input logic [2:0] t2, input logic [2:0] rob);
    op_t o;
    o.op = op; o.v1 = v1; o.r1 = r1; o.t1 = t1;
    o.v2 = v2; o.r2 = r2; o.t2 = t2; o.rob = rob;
    return o;
  endfunction

  function automatic op_t wake_op(input op_t e);
    op_t r;
    r = e;
    if (bus.cdb_valid) begin
      if (!r.r1 && r.t1 == bus.cdb_tag) begin r.r1 = 1'b1; r.v1 = bus.cdb_value; end
      if (!r.r2 && r.t2 == bus.cdb_tag) begin r.r2 = 1'b1; r.v2 = bus.cdb_value; end
    end
    return r;
  endfunction

  task automatic model_reset();
    q.delete();
    busy = 1'b0;
    iss = mk(3'b000, 32'h0, 1'b0, 3'h0, 32'h0, 1'b0, 3'h0, 3'h0);
    exp_load = 1'b0; exp_res_v = 1'b0; exp_taken = 1'b0; exp_tag = 3'h0;
  endtask

  // Predicts the state after the coming rising edge from the inputs currently driven.
  task automatic model_edge();
    bit  full;
    int  k;
    op_t n;
    exp_load  = 1'b0;
    exp_res_v = 1'b0;
    if (bus.flush) begin
      q.delete();
      busy = 1'b0;
      return;
    end
    full = (q.size() >= DEPTH);
    if (busy) begin
      if (bus.cmp_ready) begin
        exp_res_v = 1'b1;
        exp_tag   = iss.rob;
        exp_taken = bus.cmp_f;
        busy      = 1'b0;
      end
    end else begin
      k = -1;
      foreach (q[i]) if (k < 0 && q[i].r1 && q[i].r2) k = i;
      if (k >= 0) begin
        iss = q[k];
        q.delete(k);
        busy     = 1'b1;
        exp_load = 1'b1;
      end
    end
    foreach (q[i]) q[i] = wake_op(q[i]);
    if (bus.alloc_valid && !full) begin
      n = mk(bus.alloc_cmpop, bus.alloc_src1_val, bus.alloc_src1_rdy, bus.alloc_src1_tag,
             bus.alloc_src2_val, bus.alloc_src2_rdy, bus.alloc_src2_tag, bus.alloc_rob_tag);
      q.push_back(wake_op(n));
    end
  endtask

  task automatic model_compare();
    check("m_alloc_ready", bus.alloc_ready, q.size() < DEPTH);
    check("m_cmp_load", bus.cmp_load, exp_load);
    check("m_cmp_op", bus.cmp_op, iss.op);
    check("m_cmp_a", bus.cmp_a, iss.v1);
    check("m_cmp_b", bus.cmp_b, iss.v2);
    check("m_res_valid", bus.res_valid, exp_res_v);
    if (exp_res_v) begin
      check("m_res_rob_tag", bus.res_rob_tag, exp_tag);
      check("m_res_taken", bus.res_taken, exp_taken);
    end
  endtask

  // Comparator stand-in: answers a load after 1+wait_cnt cycles with the true branch outcome.
  task automatic comparator();
    if (auto_cmp) begin
      bus.cmp_ready = 1'b0;
      if (pend) begin
        if (wait_cnt == 0) begin
          bus.cmp_ready = 1'b1;
          bus.cmp_f     = ref_cmp(bus.cmp_op, bus.cmp_a, bus.cmp_b);
          pend          = 1'b0;
        end else begin
          wait_cnt--;
        end
      end
      if (bus.cmp_load) begin
        pend     = 1'b1;
        wait_cnt = $urandom_range(cmp_delay_max, 0);
      end
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    model_compare();
    comparator();
  endtask

  task automatic drain(input int n);
    repeat (n) step();
  endtask

  task automatic clear_inputs();
    bus.alloc_valid = 1'b0; bus.alloc_cmpop = 3'h0;
    bus.alloc_src1_val = '0; bus.alloc_src2_val = '0;
    bus.alloc_src1_rdy = 1'b0; bus.alloc_src2_rdy = 1'b0;
    bus.alloc_src1_tag = '0; bus.alloc_src2_tag = '0; bus.alloc_rob_tag = '0;
    bus.cdb_valid = 1'b0; bus.cdb_tag = '0; bus.cdb_value = '0;
    bus.flush = 1'b0;
  endtask

  task automatic set_alloc(input op_t o);
    bus.alloc_valid    = 1'b1;
    bus.alloc_cmpop    = o.op;
    bus.alloc_src1_val = o.v1; bus.alloc_src1_rdy = o.r1; bus.alloc_src1_tag = o.t1;
    bus.alloc_src2_val = o.v2; bus.alloc_src2_rdy = o.r2; bus.alloc_src2_tag = o.t2;
    bus.alloc_rob_tag  = o.rob;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_alloc_ready"}, bus.alloc_ready, 1'b1);
    check({tag, "_cmp_load"}, bus.cmp_load, 1'b0);
    check({tag, "_cmp_op"}, bus.cmp_op, 3'h0);
    check({tag, "_cmp_a"}, bus.cmp_a, 32'h0);
    check({tag, "_cmp_b"}, bus.cmp_b, 32'h0);
    check({tag, "_res_valid"}, bus.res_valid, 1'b0);
    check({tag, "_res_rob_tag"}, bus.res_rob_tag, 3'h0);
    check({tag, "_res_taken"}, bus.res_taken, 1'b0);
  endtask

  vec_t       vecs[7];
  logic [2:0] order[$];
  logic [2:0] exp_order[4];
  logic [2:0] wake_tags[3];
  logic [2:0] ops[6];
  op_t        r;

  initial begin
    vecs[0] = '{op: 3'b100, a: 32'hFFFF_FFFF, b: 32'h1,         rob: 3'd2, taken: 1'b1};
    vecs[1] = '{op: 3'b110, a: 32'hFFFF_FFFF, b: 32'h1,         rob: 3'd3, taken: 1'b0};
    vecs[2] = '{op: 3'b000, a: 32'h5,         b: 32'h5,         rob: 3'd4, taken: 1'b1};
    vecs[3] = '{op: 3'b001, a: 32'h5,         b: 32'h5,         rob: 3'd5, taken: 1'b0};
    vecs[4] = '{op: 3'b101, a: 32'h8000_0000, b: 32'h0,         rob: 3'd6, taken: 1'b0};
    vecs[5] = '{op: 3'b111, a: 32'h8000_0000, b: 32'h0,         rob: 3'd7, taken: 1'b1};
    vecs[6] = '{op: 3'b101, a: 32'h3,         b: 32'h3,         rob: 3'd1, taken: 1'b1};
    exp_order[0] = 3'd2; exp_order[1] = 3'd0; exp_order[2] = 3'd1; exp_order[3] = 3'd3;
    wake_tags[0] = 3'd1; wake_tags[1] = 3'd2; wake_tags[2] = 3'd4;
    ops[0] = 3'b000; ops[1] = 3'b001; ops[2] = 3'b100;
    ops[3] = 3'b101; ops[4] = 3'b110; ops[5] = 3'b111;

    n_checks = 0; n_errors = 0;
    auto_cmp = 1'b1; pend = 1'b0; wait_cnt = 0; cmp_delay_max = 0;
    bus.cmp_ready = 1'b0; bus.cmp_f = 1'b0;
    clear_inputs();
    model_reset();

    #12;
    check_all_zero("reset");
    rst = 1'b1;
    step();

    // Single ready-at-dispatch ops: load one cycle after entry, result three cycles after.
    for (int i = 0; i < 7; i++) begin
      set_alloc(mk(vecs[i].op, vecs[i].a, 1'b1, 3'h0, vecs[i].b, 1'b1, 3'h0, vecs[i].rob));
      step();
      clear_inputs();
      step();
      check("vec_load", bus.cmp_load, 1'b1);
      check("vec_op", bus.cmp_op, vecs[i].op);
      check("vec_a", bus.cmp_a, vecs[i].a);
      check("vec_b", bus.cmp_b, vecs[i].b);
      step();
      check("vec_load_pulse", bus.cmp_load, 1'b0);
      check("vec_a_held", bus.cmp_a, vecs[i].a);
      step();
      check("vec_res_valid", bus.res_valid, 1'b1);
      check("vec_res_tag", bus.res_rob_tag, vecs[i].rob);
      check("vec_res_taken", bus.res_taken, vecs[i].taken);
      step();
      check("vec_res_pulse", bus.res_valid, 1'b0);
    end

    // CDB wakeup one cycle after allocation.
    set_alloc(mk(3'b000, 32'd7, 1'b1, 3'h0, 32'h0, 1'b0, 3'd5, 3'd1));
    step();
    clear_inputs();
    bus.cdb_valid = 1'b1; bus.cdb_tag = 3'd5; bus.cdb_value = 32'd7;
    step();
    clear_inputs();
    check("cdb_no_early_load", bus.cmp_load, 1'b0);
    step();
    check("cdb_load", bus.cmp_load, 1'b1);
    check("cdb_b", bus.cmp_b, 32'd7);
    drain(6);

    // CDB broadcast in the allocation cycle (bypass).
    set_alloc(mk(3'b000, 32'd9, 1'b1, 3'h0, 32'h0, 1'b0, 3'd5, 3'd2));
    bus.cdb_valid = 1'b1; bus.cdb_tag = 3'd5; bus.cdb_value = 32'd9;
    step();
    clear_inputs();
    step();
    check("byp_load", bus.cmp_load, 1'b1);
    check("byp_b", bus.cmp_b, 32'd9);
    drain(6);

    // Fill all entries with src1 pending; wake only the third one.
    for (int i = 0; i < 4; i++) begin
      set_alloc(mk(3'b001, 32'h0, 1'b0, 3'(i + 1), 32'(100 + i), 1'b1, 3'h0, 3'(i)));
      step();
    end
    clear_inputs();
    check("full_alloc_ready", bus.alloc_ready, 1'b0);
    bus.cdb_valid = 1'b1; bus.cdb_tag = 3'd3; bus.cdb_value = 32'h33;
    set_alloc(mk(3'b000, 32'h1, 1'b1, 3'h0, 32'h1, 1'b1, 3'h0, 3'd7));
    step();
    clear_inputs();
    check("issue_cycle_alloc_ready", bus.alloc_ready, 1'b0);
    set_alloc(mk(3'b000, 32'h1, 1'b1, 3'h0, 32'h1, 1'b1, 3'h0, 3'd7));
    step();
    clear_inputs();
    check("full_issue_load", bus.cmp_load, 1'b1);
    check("full_issue_a", bus.cmp_a, 32'h33);
    check("full_issue_b", bus.cmp_b, 32'd102);
    check("after_issue_alloc_ready", bus.alloc_ready, 1'b1);

    begin
      int last_load;
      last_load = -1;
      order.delete();
      for (int c = 0; c < 40 && order.size() < 4; c++) begin
        if (c < 3) begin
          bus.cdb_valid = 1'b1; bus.cdb_tag = wake_tags[c]; bus.cdb_value = 32'(c);
        end else begin
          bus.cdb_valid = 1'b0;
        end
        step();
        if (bus.res_valid) order.push_back(bus.res_rob_tag);
        if (bus.cmp_load) begin
          if (last_load >= 0) check("load_gap_ge2", (c - last_load) >= 2, 1'b1);
          last_load = c;
        end
      end
      clear_inputs();
      check("order_count", order.size(), 4);
      for (int k = 0; k < order.size() && k < 4; k++) check("issue_order", order[k], exp_order[k]);
    end
    drain(2);

    // Flush while waiting on the comparator with three ops queued.
    auto_cmp = 1'b0; pend = 1'b0; bus.cmp_ready = 1'b0;
    set_alloc(mk(3'b000, 32'h1, 1'b1, 3'h0, 32'h1, 1'b1, 3'h0, 3'd1));
    step();
    for (int i = 0; i < 3; i++) begin
      set_alloc(mk(3'b000, 32'h0, 1'b0, 3'd6, 32'h0, 1'b0, 3'd6, 3'(2 + i)));
      step();
    end
    clear_inputs();
    bus.flush = 1'b1;
    set_alloc(mk(3'b000, 32'h4, 1'b1, 3'h0, 32'h4, 1'b1, 3'h0, 3'd6));
    step();
    clear_inputs();
    check("flush_alloc_ready", bus.alloc_ready, 1'b1);
    check("flush_load", bus.cmp_load, 1'b0);
    check("flush_res_valid", bus.res_valid, 1'b0);
    bus.cmp_ready = 1'b1; bus.cmp_f = 1'b1;
    step();
    bus.cmp_ready = 1'b0;
    check("flush_late_ready_res", bus.res_valid, 1'b0);
    step();
    check("flush_late_ready_res2", bus.res_valid, 1'b0);
    check("flush_dropped_alloc", bus.cmp_load, 1'b0);

    // Asynchronous reset between edges while in WAIT.
    set_alloc(mk(3'b100, 32'd2, 1'b1, 3'h0, 32'd3, 1'b1, 3'h0, 3'd5));
    step();
    clear_inputs();
    step();
    check("rst_pre_load", bus.cmp_load, 1'b1);
    step();
    #1 rst = 1'b0;
    #1;
    check_all_zero("async_rst");
    model_reset();
    #1 rst = 1'b1;
    auto_cmp = 1'b1; pend = 1'b0;
    set_alloc(mk(3'b101, 32'd9, 1'b1, 3'h0, 32'd2, 1'b1, 3'h0, 3'd3));
    step();
    clear_inputs();
    check("rst_no_stale_res", bus.res_valid, 1'b0);
    step();
    check("rst_new_load", bus.cmp_load, 1'b1);
    check("rst_new_a", bus.cmp_a, 32'd9);
    step();
    step();
    check("rst_new_res_valid", bus.res_valid, 1'b1);
    check("rst_new_res_tag", bus.res_rob_tag, 3'd3);
    check("rst_new_res_taken", bus.res_taken, 1'b1);
    drain(2);

    // Random traffic against the reference model.
    cmp_delay_max = 3;
    for (int c = 0; c < 2500; c++) begin
      step();
      r = mk(ops[$urandom_range(5)],
             ($urandom_range(1) != 0) ? $urandom : 32'($urandom_range(3)),
             $urandom_range(99) < 60, 3'($urandom_range(7)),
             ($urandom_range(1) != 0) ? $urandom : 32'($urandom_range(3)),
             $urandom_range(99) < 60, 3'($urandom_range(7)),
             3'($urandom_range(7)));
      set_alloc(r);
      bus.alloc_valid = ($urandom_range(99) < 50);
      bus.cdb_valid   = ($urandom_range(99) < 40);
      bus.cdb_tag     = 3'($urandom_range(7));
      bus.cdb_value   = ($urandom_range(1) != 0) ? $urandom : 32'($urandom_range(3));
      bus.flush       = ($urandom_range(99) < 3);
      if (!bus.cmp_ready && $urandom_range(99) < 4) begin
        bus.cmp_ready = 1'b1;
        bus.cmp_f     = 1'($urandom_range(1));
      end
    end
    clear_inputs();
    drain(12);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
